remote_update_responder: RTL and testbench
==========================================

// Module: remote_update_responder
// PURPOSE
//  Synthesizable responder for the remote-update parameter interface (param/data_in/
//  write_param/read_param/busy/data_out/reconfig). Stands in for the vendor remote-update
//  block on targets without one and in bootloader benches. Holds the update registers,
//  reports the last-config reason and raises a reconfiguration request.
// PARAMETERS
//  BUSY_CYCLES   4   cycles busy stays high per accepted read or write (>=1)
//  RECONFIG_MIN  5   consecutive cycles reconfig must be high before a request
//  WD_EN_DEFAULT 1   reset value of watchdog_en
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-low
//  param         in   3   register select
//  data_in       in   22  write data
//  write_param   in   1   write strobe, sampled when idle
//  read_param    in   1   read strobe, sampled when idle
//  read_source   in   2   00 current, 01/10 previous config, 11 input register
//  reconfig      in   1   reconfiguration request level
//  last_reason   in   5   reason for the previous configuration
//  busy          out  1   operation in progress
//  data_out      out  24  read result
//  boot_address  out  24  application boot address {reg,2'b00}
//  watchdog_en   out  1   param 011
//  wd_timeout    out  12  param 010
//  osc_int       out  1   param 110
//  early_cd      out  1   param 001
//  reconfig_req  out  1   one-cycle reconfiguration pulse
//  protocol_err  out  1   sticky: strobe not accepted
// BEHAVIOUR
//  Reset (reset==0 at posedge): busy=0, data_out=0, boot_address=0, watchdog_en=WD_EN_DEFAULT,
//   wd_timeout=0, osc_int=0, early_cd=0, reconfig_req=0, protocol_err=0, FSM=IDLE, counters 0.
//   Reset mid-operation aborts it; the pending write is not committed.
//  FSM IDLE / WBUSY / RBUSY / RECONF.
//  IDLE: write_param=1 -> latch param,data_in; busy=1 from next cycle; -> WBUSY.
//   read_param=1 -> latch param,read_source; busy=1 from next cycle; -> RBUSY.
//   Both high -> write wins, read dropped, protocol_err=1.
//  WBUSY/RBUSY: busy held exactly BUSY_CYCLES cycles; on the last busy cycle the write is
//   committed / data_out loaded; busy=0 next cycle; -> IDLE. Strobes while busy are
//   ignored and set protocol_err.
//  Write map: 001 early_cd=d[0]; 010 wd_timeout=d[11:0]; 011 watchdog_en=d[0];
//   100 boot_address={d[21:0],2'b00}; 110 osc_int=d[0]; 000,101,111 read-only, write
//   completes (busy cycle runs), no state change.
//  Read map (zero-extended to 24): 000 {FSM state}; 001/011/110 bit; 010 wd_timeout;
//   100 boot_address; 111 last_reason for source 00/01/10, 0 for 11; 101 -> 0.
//  data_out holds until the next completed read.
//  Reconfig: counter counts consecutive reconfig-high cycles in IDLE only. Clears when
//   reconfig=0 or when not IDLE. At count==RECONFIG_MIN -> reconfig_req=1 for one cycle,
//   -> RECONF. RECONF: busy=1 constantly; all strobes ignored (no error); exit only by reset.
//   reconfig high during busy neither counts nor errors.
// TESTING
//  T1 write param 100 data 22'h028000 -> busy high 4 cycles, then boot_address=24'h0A0000.
//  T2 last_reason=5'b01000, read 111 src 00 -> after busy falls data_out=24'h000008.
//  T3 reconfig high 4 cycles then low -> no reconfig_req; high 5 cycles -> one-cycle
//     reconfig_req on 5th, busy stays 1 until reset.
//  T4 write_param during WBUSY -> ignored, protocol_err=1, first write still committed.
//  T5 write 011 d=0 and read 010 in same cycle -> watchdog_en=0, data_out unchanged,
//     protocol_err=1.
//  T6 reset low on 2nd busy cycle of write 110 d=1 -> osc_int=0, busy=0 next cycle.

Source files
------------

// File: rtl/remote_update_responder.sv
// Stand-in responder for the remote-update parameter interface: holds the update
// registers, answers reads after a fixed busy window and raises a reconfiguration pulse.
module remote_update_responder #(
  parameter int BUSY_CYCLES   = 4,
  parameter int RECONFIG_MIN  = 5,
  parameter bit WD_EN_DEFAULT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  param,
  input  logic [21:0] data_in,
  input  logic        write_param,
  input  logic        read_param,
  input  logic [1:0]  read_source,
  input  logic        reconfig,
  input  logic [4:0]  last_reason,
  output logic        busy,
  output logic [23:0] data_out,
  output logic [23:0] boot_address,
  output logic        watchdog_en,
  output logic [11:0] wd_timeout,
  output logic        osc_int,
  output logic        early_cd,
  output logic        reconfig_req,
  output logic        protocol_err
);

  localparam int BW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam int RW = $clog2(RECONFIG_MIN + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BUSY_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RECONFIG_MIN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBUSY  = 2'd1,
    RBUSY  = 2'd2,
    RECONF = 2'd3
  } state_t;

  // Handshake: a strobe is accepted only on a posedge that sees the FSM in IDLE;
  // busy rises the following cycle and stays high for BUSY_CYCLES cycles, and the
  // write commits / data_out loads on the edge that ends the last busy cycle.
  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    param_q, param_d;
  logic [21:0]   wdata_q, wdata_d;
  logic [1:0]    src_q, src_d;
  logic [23:0]   data_out_q, data_out_d;
  logic [23:0]   boot_q, boot_d;
  logic          wd_en_q, wd_en_d;
  logic [11:0]   wd_to_q, wd_to_d;
  logic          osc_q, osc_d;
  logic          ecd_q, ecd_d;
  logic          req_q, req_d;
  logic          perr_q, perr_d;
  logic [23:0]   rd_val;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      rcnt_q     <= '0;
      param_q    <= '0;
      wdata_q    <= '0;
      src_q      <= '0;
      data_out_q <= '0;
      boot_q     <= '0;
      wd_en_q    <= WD_EN_DEFAULT;
      wd_to_q    <= '0;
      osc_q      <= 1'b0;
      ecd_q      <= 1'b0;
      req_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      rcnt_q     <= rcnt_d;
      param_q    <= param_d;
      wdata_q    <= wdata_d;
      src_q      <= src_d;
      data_out_q <= data_out_d;
      boot_q     <= boot_d;
      wd_en_q    <= wd_en_d;
      wd_to_q    <= wd_to_d;
      osc_q      <= osc_d;
      ecd_q      <= ecd_d;
      req_q      <= req_d;
      perr_q     <= perr_d;
    end
  end

  // Read value is sampled on the completing edge, so register 000 reports RBUSY.
  always_comb begin
    rd_val = '0;
    case (param_q)
      3'b000:  rd_val = {22'd0, state_q};
      3'b001:  rd_val = {23'd0, ecd_q};
      3'b010:  rd_val = {12'd0, wd_to_q};
      3'b011:  rd_val = {23'd0, wd_en_q};
      3'b100:  rd_val = boot_q;
      3'b110:  rd_val = {23'd0, osc_q};
      3'b111:  rd_val = (src_q == 2'b11) ? 24'd0 : {19'd0, last_reason};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    rcnt_d     = '0;
    param_d    = param_q;
    wdata_d    = wdata_q;
    src_d      = src_q;
    data_out_d = data_out_q;
    boot_d     = boot_q;
    wd_en_d    = wd_en_q;
    wd_to_d    = wd_to_q;
    osc_d      = osc_q;
    ecd_d      = ecd_q;
    req_d      = 1'b0;
    perr_d     = perr_q;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (reconfig && rcnt_q == R_LAST) begin
          req_d   = 1'b1;
          state_d = RECONF;
        end else begin
          if (reconfig) rcnt_d = rcnt_q + RW'(1);
          if (write_param) begin
            param_d = param;
            wdata_d = data_in;
            state_d = WBUSY;
            rcnt_d  = '0;
            if (read_param) perr_d = 1'b1;
          end else if (read_param) begin
            param_d = param;
            src_d   = read_source;
            state_d = RBUSY;
            rcnt_d  = '0;
          end
        end
      end
      WBUSY, RBUSY: begin
        if (write_param || read_param) perr_d = 1'b1;
        if (bcnt_q == B_LAST) begin
          bcnt_d  = '0;
          state_d = IDLE;
          if (state_q == RBUSY) begin
            data_out_d = rd_val;
          end else begin
            case (param_q)
              3'b001:  ecd_d   = wdata_q[0];
              3'b010:  wd_to_d = wdata_q[11:0];
              3'b011:  wd_en_d = wdata_q[0];
              3'b100:  boot_d  = {wdata_q, 2'b00};
              3'b110:  osc_d   = wdata_q[0];
              default: ;
            endcase
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign data_out     = data_out_q;
  assign boot_address = boot_q;
  assign watchdog_en  = wd_en_q;
  assign wd_timeout   = wd_to_q;
  assign osc_int      = osc_q;
  assign early_cd     = ecd_q;
  assign reconfig_req = req_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_remote_update_responder.sv
// Bench for remote_update_responder: table of single transactions with full expected
// register state, then hand-written sequences for error, reset and reconfig cases.
module tb_remote_update_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  param = '0;
  logic [21:0] data_in = '0;
  logic        write_param = 1'b0;
  logic        read_param = 1'b0;
  logic [1:0]  read_source = '0;
  logic        reconfig = 1'b0;
  logic [4:0]  last_reason = '0;
  logic        busy;
  logic [23:0] data_out;
  logic [23:0] boot_address;
  logic        watchdog_en;
  logic [11:0] wd_timeout;
  logic        osc_int;
  logic        early_cd;
  logic        reconfig_req;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  remote_update_responder dut (
    .clock(clock), .reset(reset), .param(param), .data_in(data_in),
    .write_param(write_param), .read_param(read_param), .read_source(read_source),
    .reconfig(reconfig), .last_reason(last_reason), .busy(busy), .data_out(data_out),
    .boot_address(boot_address), .watchdog_en(watchdog_en), .wd_timeout(wd_timeout),
    .osc_int(osc_int), .early_cd(early_cd), .reconfig_req(reconfig_req),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [2:0]  p;
    logic [21:0] d;
    logic [1:0]  s;
    logic [4:0]  r;
    logic [23:0] e_boot;
    logic [11:0] e_wdt;
    logic        e_wden;
    logic        e_osc;
    logic        e_ecd;
    logic [23:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic run_op(input bit wr, input logic [2:0] p, input logic [21:0] d,
                        input logic [1:0] s);
    int n;
    param = p; data_in = d; read_source = s;
    write_param = wr; read_param = !wr;
    step();
    write_param = 1'b0; read_param = 1'b0;
    wait_idle(n);
    chk("busy_len", n, 4);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic chk_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_boot", boot_address, 0);
    chk("rst_wden", watchdog_en, 1);
    chk("rst_wdt", wd_timeout, 0);
    chk("rst_osc", osc_int, 0);
    chk("rst_ecd", early_cd, 0);
    chk("rst_req", reconfig_req, 0);
    chk("rst_perr", protocol_err, 0);
  endtask

  initial begin
    int n;
    // wr p d s r | boot wdt wden osc ecd dout
    vecs.push_back('{1, 3'b100, 22'h028000, 2'd0, 5'h00, 24'h0A0000, 12'h000, 1, 0, 0, 24'h000000});
    vecs.push_back('{1, 3'b010, 22'h3FFABC, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 1, 0, 0, 24'h000000});
    vecs.push_back('{1, 3'b001, 22'h000001, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 1, 0, 1, 24'h000000});
    vecs.push_back('{1, 3'b110, 22'h000001, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 1, 1, 1, 24'h000000});
    vecs.push_back('{1, 3'b011, 22'h3FFFFE, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000000});
    vecs.push_back('{1, 3'b000, 22'h3FFFFF, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000000});
    vecs.push_back('{1, 3'b101, 22'h3FFFFF, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000000});
    vecs.push_back('{1, 3'b111, 22'h3FFFFF, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000000});
    vecs.push_back('{0, 3'b100, 22'h000000, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h0A0000});
    vecs.push_back('{0, 3'b010, 22'h000000, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000ABC});
    vecs.push_back('{0, 3'b001, 22'h000000, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000001});
    vecs.push_back('{0, 3'b011, 22'h000000, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000000});
    vecs.push_back('{0, 3'b110, 22'h000000, 2'd0, 5'h00, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000001});
    vecs.push_back('{0, 3'b111, 22'h000000, 2'd0, 5'h08, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000008});
    vecs.push_back('{0, 3'b111, 22'h000000, 2'd3, 5'h1F, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000000});
    vecs.push_back('{0, 3'b111, 22'h000000, 2'd2, 5'h1F, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h00001F});
    vecs.push_back('{0, 3'b101, 22'h000000, 2'd0, 5'h1F, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000000});
    vecs.push_back('{0, 3'b000, 22'h000000, 2'd0, 5'h1F, 24'h0A0000, 12'hABC, 0, 1, 1, 24'h000002});
    vecs.push_back('{1, 3'b100, 22'h3FFFFF, 2'd0, 5'h00, 24'hFFFFFC, 12'hABC, 0, 1, 1, 24'h000002});
    vecs.push_back('{0, 3'b100, 22'h000000, 2'd0, 5'h00, 24'hFFFFFC, 12'hABC, 0, 1, 1, 24'hFFFFFC});

    // Reset state is checked while reset is still asserted and after release.
    step();
    step();
    chk_reset_state();
    reset = 1'b1;
    step();
    chk_reset_state();

    foreach (vecs[i]) begin
      last_reason = vecs[i].r;
      run_op(vecs[i].wr, vecs[i].p, vecs[i].d, vecs[i].s);
      chk($sformatf("v%0d_boot", i), boot_address, vecs[i].e_boot);
      chk($sformatf("v%0d_wdt", i), wd_timeout, vecs[i].e_wdt);
      chk($sformatf("v%0d_wden", i), watchdog_en, vecs[i].e_wden);
      chk($sformatf("v%0d_osc", i), osc_int, vecs[i].e_osc);
      chk($sformatf("v%0d_ecd", i), early_cd, vecs[i].e_ecd);
      chk($sformatf("v%0d_dout", i), data_out, vecs[i].e_dout);
      chk($sformatf("v%0d_perr", i), protocol_err, 0);
    end

    // Second write during WBUSY is ignored but flagged; the first write commits.
    param = 3'b001; data_in = 22'h000000; write_param = 1'b1;
    step();
    chk("t4_busy", busy, 1);
    param = 3'b001; data_in = 22'h000001; write_param = 1'b1;
    step();
    write_param = 1'b0;
    wait_idle(n);
    chk("t4_len", n, 3);
    chk("t4_ecd", early_cd, 0);
    chk("t4_perr", protocol_err, 1);
    step();
    chk("t4_idle", busy, 0);

    // Simultaneous write and read: write wins, data_out keeps its last read value.
    do_reset();
    chk("t5_perr_clr", protocol_err, 0);
    run_op(1'b1, 3'b100, 22'h000123, 2'd0);
    run_op(1'b0, 3'b100, 22'h000000, 2'd0);
    chk("t5_dout0", data_out, 24'h00048C);
    param = 3'b011; data_in = 22'h000000; read_source = 2'd0;
    write_param = 1'b1; read_param = 1'b1;
    step();
    write_param = 1'b0; read_param = 1'b0;
    wait_idle(n);
    chk("t5_len", n, 4);
    chk("t5_wden", watchdog_en, 0);
    chk("t5_dout", data_out, 24'h00048C);
    chk("t5_perr", protocol_err, 1);

    // Reset on the second busy cycle aborts the write.
    do_reset();
    param = 3'b110; data_in = 22'h000001; write_param = 1'b1;
    step();
    write_param = 1'b0;
    chk("t6_busy1", busy, 1);
    step();
    chk("t6_busy2", busy, 1);
    reset = 1'b0;
    step();
    chk("t6_busy_rst", busy, 0);
    chk("t6_osc_rst", osc_int, 0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t6_busy_after", busy, 0);
    chk("t6_osc_after", osc_int, 0);

    // Reconfig one cycle short of the threshold must not trigger.
    reconfig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3a_req%0d", i), reconfig_req, 0);
    end
    reconfig = 1'b0;
    step();
    chk("t3a_req_low", reconfig_req, 0);
    chk("t3a_busy", busy, 0);

    // Full threshold: one-cycle pulse on the fifth high cycle, then locked busy.
    reconfig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3b_req%0d", i), reconfig_req, 0);
      chk($sformatf("t3b_busy%0d", i), busy, 0);
    end
    step();
    chk("t3b_req5", reconfig_req, 1);
    chk("t3b_busy5", busy, 1);
    reconfig = 1'b0;
    step();
    chk("t3b_req_end", reconfig_req, 0);
    chk("t3b_busy_hold", busy, 1);
    param = 3'b100; data_in = 22'h000111; write_param = 1'b1; read_param = 1'b1;
    step();
    write_param = 1'b0; read_param = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t3b_busy_lock", busy, 1);
    chk("t3b_perr", protocol_err, 0);
    chk("t3b_boot", boot_address, 0);
    do_reset();
    chk("t3b_busy_rst", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
